// File: rtl/dma_pkg.sv
// Shared types and constants for the multi-channel DMA engine: FSM states,
// descriptor increment-bit positions and the system memory map.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } dma_state_t;

    localparam int INCR_SRC = 0;
    localparam int INCR_DST = 1;

    // System memory map: two I/O port windows followed by RAM.
    localparam int IO1_BASE = 0;
    localparam int IO1_LAST = 31;
    localparam int IO2_BASE = 32;
    localparam int IO2_LAST = 63;
    localparam int RAM_BASE = 64;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin channel picker: the search starts at the channel after the last
// one served and returns a one-hot grant plus its binary index.
module dma_rr_arbiter #(
    parameter  int CHANNELS = 4,
    localparam int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [CH_W-1:0]     idx
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] cand;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = CH_W'((int'(ptr) + i) % CHANNELS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == CH_W'(CHANNELS - 1)) ? '0 : idx + CH_W'(1);
        end
    end

endmodule

// File: rtl/dma_multichannel.sv
// Multi-channel DMA engine: per-channel descriptors served one word at a time
// in round-robin order over a shared bus, with a done pulse per channel.
module dma_multichannel
    import dma_pkg::*;
#(
    parameter  int DW       = 32,
    parameter  int AW       = 32,
    parameter  int CHANNELS = 4,
    parameter  int LEN_W    = 6,
    localparam int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [AW-1:0]       cfg_src,
    input  logic [AW-1:0]       cfg_dst,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [1:0]          cfg_incr,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic [AW-1:0]       bus_addr,
    output logic                bus_rd,
    output logic                bus_wr,
    output logic [DW-1:0]       bus_wdata,
    input  logic [DW-1:0]       bus_rdata
);

    function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] addr, input logic en);
        return en ? addr + AW'(1) : addr;
    endfunction

    logic [AW-1:0]       src_q  [CHANNELS];
    logic [AW-1:0]       dst_q  [CHANNELS];
    logic [LEN_W-1:0]    len_q  [CHANNELS];
    logic [1:0]          incr_q [CHANNELS];

    logic [CHANNELS-1:0] busy_q;
    logic [CHANNELS-1:0] done_q;
    logic [CHANNELS-1:0] set_mask;
    logic [CHANNELS-1:0] clr_mask;
    logic [CHANNELS-1:0] arb_grant;
    logic [CH_W-1:0]     arb_idx;
    logic [CH_W-1:0]     cur_ch;
    logic                cfg_err_q;
    logic                chan_ok;
    logic                accept;
    logic                last_word;
    logic                advance;
    logic [DW-1:0]       word_p0;
    dma_state_t          state;
    dma_state_t          state_nx;

    dma_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (busy_q),
        .advance (advance),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    // A busy channel stays busy through its final WR cycle, so a write landing
    // on that cycle is rejected rather than silently replacing the descriptor.
    assign chan_ok   = ({1'b0, cfg_chan} < (CH_W + 1)'(CHANNELS));
    assign accept    = cfg_we && chan_ok && (cfg_len != '0) && !busy_q[cfg_chan];
    assign last_word = (state == WR) && (len_q[cur_ch] == LEN_W'(1));

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (accept) begin
            set_mask[cfg_chan] = 1'b1;
        end
        if (last_word) begin
            clr_mask[cur_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                src_q[i]  <= '0;
                dst_q[i]  <= '0;
                len_q[i]  <= '0;
                incr_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                src_q[cfg_chan]  <= cfg_src;
                dst_q[cfg_chan]  <= cfg_dst;
                len_q[cfg_chan]  <= cfg_len;
                incr_q[cfg_chan] <= cfg_incr;
            end
            if (state == WR) begin
                src_q[cur_ch] <= step_addr(src_q[cur_ch], incr_q[cur_ch][INCR_SRC]);
                dst_q[cur_ch] <= step_addr(dst_q[cur_ch], incr_q[cur_ch][INCR_DST]);
                len_q[cur_ch] <= len_q[cur_ch] - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy_q    <= '0;
            done_q    <= '0;
            cfg_err_q <= 1'b0;
            cur_ch    <= '0;
        end else begin
            state     <= state_nx;
            busy_q    <= (busy_q & ~clr_mask) | set_mask;
            done_q    <= clr_mask;
            cfg_err_q <= cfg_we && !accept;
            if (advance) begin
                cur_ch <= arb_idx;
            end
        end
    end

    // CAP stage: the memory's registered read data is valid in this cycle.
    always_ff @(posedge clk) begin
        if (state == CAP) begin
            word_p0 <= bus_rdata;
        end
    end

    always_comb begin
        state_nx  = state;
        advance   = 1'b0;
        bus_addr  = '0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_wdata = '0;
        case (state)
            IDLE: begin
                if (bus_gnt && (|arb_grant)) begin
                    advance  = 1'b1;
                    state_nx = RD;
                end
            end
            RD: begin
                bus_addr = src_q[cur_ch];
                bus_rd   = 1'b1;
                state_nx = CAP;
            end
            CAP: begin
                state_nx = WR;
            end
            WR: begin
                bus_addr  = dst_q[cur_ch];
                bus_wr    = 1'b1;
                bus_wdata = word_p0;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign bus_req = |busy_q;

endmodule

// File: tb/tb_dma_multichannel.sv
// Directed plus randomized bench for dma_multichannel against a word-level
// reference model of descriptor service, memory contents and done timing.
module tb_dma_multichannel;
    import dma_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int C = 4;
    localparam int LEN_W = 6;
    localparam int CH_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_chan;
    logic [AW-1:0]    cfg_src;
    logic [AW-1:0]    cfg_dst;
    logic [LEN_W-1:0] cfg_len;
    logic [1:0]       cfg_incr;
    logic             cfg_err;
    logic [C-1:0]     busy;
    logic [C-1:0]     done;
    logic             bus_req;
    logic             bus_gnt;
    logic [AW-1:0]    bus_addr;
    logic             bus_rd;
    logic             bus_wr;
    logic [DW-1:0]    bus_wdata;
    logic [DW-1:0]    bus_rdata;

    dma_multichannel #(.DW(DW), .AW(AW), .CHANNELS(C), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_incr(cfg_incr),
        .cfg_err(cfg_err), .busy(busy), .done(done), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        load_mem;
    logic [31:0] init_mem [256];
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log [$];
    logic [31:0] exp_rd [$];
    logic [31:0] exp_wr [$];
    int          done_cnt [C] = '{0, 0, 0, 0};
    int          done_at [C] = '{0, 0, 0, 0};
    int          dc0 [C];
    int          fw [C];
    int          model_ptr;
    logic [31:0] d_src [C];
    logic [31:0] d_dst [C];
    int          d_len [C];
    logic [1:0]  d_inc [C];

    // Memory with a registered read port, aliased to 256 words.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        end else begin
            if (bus_rd) bus_rdata <= mem[bus_addr[7:0]];
            if (bus_wr) mem[bus_addr[7:0]] <= bus_wdata;
        end
    end

    always @(negedge clk) begin
        if (bus_rd) rd_log.push_back(bus_addr);
        if (bus_wr) wr_log.push_back(bus_addr);
        for (int i = 0; i < C; i++) begin
            if (done[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_at[i]  <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int ch, input logic [31:0] s, input logic [31:0] d, input int len,
                       input logic [1:0] inc, output logic err, output int c);
        cfg_we = 1'b1; cfg_chan = CH_W'(ch); cfg_src = s; cfg_dst = d;
        cfg_len = LEN_W'(len); cfg_incr = inc; c = cyc;
        @(negedge clk);
        cfg_we = 1'b0;
        err = cfg_err;
    endtask

    task automatic load(input int ch, input logic [31:0] s, input logic [31:0] d, input int len,
                        input logic [1:0] inc, output int c);
        logic err;
        cfg(ch, s, d, len, inc, err, c);
        d_src[ch] = s; d_dst[ch] = d; d_len[ch] = len; d_inc[ch] = inc;
        chk($sformatf("load_ch%0d_err", ch), err, 0);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        for (int i = 0; i < C; i++) dc0[i] = done_cnt[i];
    endtask

    // Word-level model: round-robin from the channel after the last served,
    // each word copied src->dst in service order.
    task automatic model_run(input logic [C-1:0] loaded);
        int rem [C];
        logic [31:0] s [C];
        logic [31:0] d [C];
        int j, ch, total;
        exp_rd.delete();
        exp_wr.delete();
        total = 0;
        for (int i = 0; i < C; i++) begin
            rem[i] = loaded[i] ? d_len[i] : 0;
            s[i] = d_src[i]; d[i] = d_dst[i]; fw[i] = -1;
            total += rem[i];
        end
        for (j = 0; j < total; j++) begin
            ch = -1;
            for (int i = 0; i < C; i++) begin
                if (ch < 0 && rem[(model_ptr + i) % C] > 0) ch = (model_ptr + i) % C;
            end
            exp_rd.push_back(s[ch]);
            exp_wr.push_back(d[ch]);
            ref_mem[d[ch][7:0]] = ref_mem[s[ch][7:0]];
            if (d_inc[ch][INCR_SRC]) s[ch] = s[ch] + 32'd1;
            if (d_inc[ch][INCR_DST]) d[ch] = d[ch] + 32'd1;
            rem[ch]--;
            if (rem[ch] == 0) fw[ch] = j;
            model_ptr = (ch + 1) % C;
        end
    endtask

    task automatic mem_check(input string tag);
        int bad = -1;
        for (int i = 0; i < 256; i++) if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
        chk({tag, "_mem_first_bad"}, bad, -1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy !== '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_in_budget"}, busy, 0);
        tick(2);
    endtask

    task automatic check_run(input logic [C-1:0] loaded, input int g, input string tag);
        chk({tag, "_rd_n"}, rd_log.size(), exp_rd.size());
        chk({tag, "_wr_n"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i), rd_log[i], exp_rd[i]);
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
        for (int ch = 0; ch < C; ch++) begin
            if (loaded[ch]) begin
                chk($sformatf("%s_done%0d_n", tag, ch), done_cnt[ch] - dc0[ch], 1);
                chk($sformatf("%s_done%0d_cyc", tag, ch), done_at[ch], g + 4 * (fw[ch] + 1));
            end
        end
        mem_check(tag);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_rd"}, bus_rd, 0);
        chk({tag, "_bus_wr"}, bus_wr, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
    endtask

    initial begin
        int c, c2, g;
        logic err;
        logic [C-1:0] loaded;
        logic [31:0] rr_exp [4];

        reset = 1'b1; bus_gnt = 1'b0; cfg_we = 1'b0; cfg_chan = '0; cfg_src = '0;
        cfg_dst = '0; cfg_len = '0; cfg_incr = '0; load_mem = 1'b1; model_ptr = 0;
        for (int i = 0; i < 256; i++) init_mem[i] = $urandom;
        init_mem[IO1_BASE + 1] = 32'h0F;
        init_mem[RAM_BASE] = 32'd4; init_mem[RAM_BASE + 1] = 32'd5; init_mem[RAM_BASE + 2] = 32'd6;
        init_mem[IO2_BASE] = 32'hAB;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_mem[i];
        tick(3);
        load_mem = 1'b0;
        outputs_zero("reset");
        reset = 1'b0;
        tick(1);

        // Single word, grant held.
        clear_logs();
        bus_gnt = 1'b1;
        load(0, IO1_BASE + 1, 70, 1, 2'b11, c);
        chk("single_busy", busy, 4'b0001);
        chk("single_req", bus_req, 1);
        model_run(4'b0001);
        wait_idle(50, "single");
        check_run(4'b0001, c + 1, "single");
        chk("single_mem70", mem[70], 32'h0F);
        chk("single_done_lat", done_at[0], c + 5);

        // Block copy.
        clear_logs();
        load(1, RAM_BASE, 70, 3, 2'b11, c);
        model_run(4'b0010);
        wait_idle(80, "block");
        check_run(4'b0010, c + 1, "block");
        for (int i = 0; i < 3; i++) chk($sformatf("block_mem%0d", 70 + i), mem[70 + i], 4 + i);
        chk("block_done_lat", done_at[1], c + 13);

        // Fixed source (I/O port).
        clear_logs();
        load(2, IO2_BASE, 80, 3, 2'b10, c);
        model_run(4'b0100);
        wait_idle(80, "fixed");
        check_run(4'b0100, c + 1, "fixed");
        for (int i = 0; i < rd_log.size(); i++) chk($sformatf("fixed_rdaddr%0d", i), rd_log[i], IO2_BASE);
        for (int i = 0; i < 3; i++) chk($sformatf("fixed_mem%0d", 80 + i), mem[80 + i], 32'hAB);

        // Reject a write to a busy channel; original descriptor must finish.
        clear_logs();
        load(1, $urandom_range(0, 100), 90, 4, 2'b11, c);
        cfg(1, 32'd5, 32'd100, 2, 2'b01, err, c2);
        chk("rej_busy_err", err, 1);
        model_run(4'b0010);
        wait_idle(80, "rej_busy");
        check_run(4'b0010, c + 1, "rej_busy");

        // Reject zero length.
        cfg(2, 32'd3, 32'd120, 0, 2'b11, err, c2);
        chk("rej_len0_err", err, 1);
        chk("rej_len0_busy", busy, 0);
        tick(1);
        chk("rej_len0_err_pulse", cfg_err, 0);

        // Reject on the cycle the channel completes.
        clear_logs();
        load(1, $urandom_range(0, 100), 95, 1, 2'b11, c);
        tick(3);
        chk("rej_last_in_wr", bus_wr, 1);
        cfg(1, 32'd7, 32'd101, 3, 2'b11, err, c2);
        chk("rej_last_err", err, 1);
        chk("rej_last_done", done, 4'b0010);
        chk("rej_last_busy", busy, 0);
        model_run(4'b0010);
        wait_idle(40, "rej_last");
        check_run(4'b0010, c + 1, "rej_last");

        // Grant dropped during the first word's RD.
        clear_logs();
        load(3, $urandom_range(0, 100), 150, 4, 2'b11, c);
        tick(1);
        bus_gnt = 1'b0;
        tick(10);
        chk("gnt_pause_wr_n", wr_log.size(), 1);
        chk("gnt_pause_busy", busy, 4'b1000);
        chk("gnt_pause_rd", bus_rd, 0);
        chk("gnt_pause_nodone", done_cnt[3] - dc0[3], 0);
        g = cyc;
        bus_gnt = 1'b1;
        model_run(4'b1000);
        wait_idle(80, "gnt");
        check_run(4'b1000, g - 4, "gnt");

        // Reset during CAP of the first word.
        clear_logs();
        load(1, 32'd20, 32'd160, 3, 2'b11, c);
        tick(2);
        chk("rstmid_in_cap", {bus_rd, bus_wr}, 2'b00);
        reset = 1'b1;
        tick(1);
        outputs_zero("rstmid");
        reset = 1'b0;
        model_ptr = 0;
        tick(20);
        chk("rstmid_nodone", done_cnt[1] - dc0[1], 0);
        chk("rstmid_wr_n", wr_log.size(), 0);
        chk("rstmid_busy", busy, 0);
        mem_check("rstmid");

        // Round-robin between ch0 and ch3 loaded while the grant is low.
        clear_logs();
        bus_gnt = 1'b0;
        load(0, 32'd10, 32'd130, 2, 2'b11, c);
        load(3, 32'd40, 32'd140, 2, 2'b11, c);
        g = cyc;
        bus_gnt = 1'b1;
        model_run(4'b1001);
        wait_idle(60, "rr");
        check_run(4'b1001, g, "rr");
        rr_exp = '{32'd10, 32'd40, 32'd11, 32'd41};
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk($sformatf("rr_order%0d", i), rd_log[i], rr_exp[i]);

        // Maximum length descriptor into a fixed destination.
        clear_logs();
        load(2, 32'd0, 32'd200, 63, 2'b01, c);
        model_run(4'b0100);
        wait_idle(400, "maxlen");
        check_run(4'b0100, c + 1, "maxlen");
        chk("maxlen_done_lat", done_at[2], c + 253);

        // Source pointer wraps past all-ones.
        clear_logs();
        load(1, 32'hFFFF_FFFE, 32'd210, 4, 2'b11, c);
        model_run(4'b0010);
        wait_idle(80, "wrap");
        check_run(4'b0010, c + 1, "wrap");
        if (rd_log.size() > 2) chk("wrap_rd2_zero", rd_log[2], 0);

        // Random multi-channel batches.
        for (int it = 0; it < 8; it++) begin
            clear_logs();
            bus_gnt = 1'b0;
            loaded = C'($urandom_range(1, 15));
            for (int ch = 0; ch < C; ch++) begin
                if (loaded[ch]) begin
                    logic [31:0] s;
                    s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                    : 32'($urandom_range(IO1_BASE, IO2_LAST + 37));
                    load(ch, s, 32'(128 + ch * 30 + $urandom_range(0, 20)),
                         $urandom_range(1, 7), 2'($urandom_range(0, 3)), c);
                end
            end
            g = cyc;
            bus_gnt = 1'b1;
            model_run(loaded);
            wait_idle(200, $sformatf("rand%0d", it));
            check_run(loaded, g, $sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
